student_circuit_multimode: RTL and testbench
============================================

// Module: student_circuit_multimode
// PURPOSE
//  Parametrised successor to the single-register exam circuit. Accepts a
//  stream of WIDTH-bit samples and produces one registered result per
//  accepted sample, in one of four modes: pass, accumulate, max, sliding-window sum.
//  Sits between the testbench stimulus generator and its output signature logic.
// PARAMETERS
//  WIDTH  8  sample, accumulator and output width (bits), >=2
//  DEPTH  4  sliding-window length in samples, >=2
// PORTS
//  clk          in   1      rising-edge clock
//  clear_n      in   1      asynchronous active-low reset
//  flush        in   1      synchronous clear of all state, active-high
//  in_valid     in   1      cct_input is sampled on this edge when 1
//  mode         in   2      0=PASS 1=ACC 2=MAX 3=WINDOW (sampled with in_valid)
//  cct_input    in   WIDTH  unsigned sample
//  cct_output   out  WIDTH  registered result, holds between samples
//  out_valid    out  1      1-cycle pulse: cct_output updated this cycle
//  ovf          out  1      sticky: ACC or WINDOW sum wrapped past 2^WIDTH-1
//  window_full  out  1      DEPTH samples accepted since reset/flush
// BEHAVIOUR
//  - clear_n=0 (any time, async): cct_output=0, out_valid=0, ovf=0,
//    window_full=0. acc, win_sum, all hist[] = 0. fill=0. mode_q=PASS.
//  - Accepted sample: rising edge with clear_n=1, flush=0, in_valid=1.
//    Latency 1: result visible and out_valid=1 in the cycle after the edge.
//    No accepted sample -> out_valid=0, cct_output/acc unchanged.
//  - restart = (mode != mode_q) on an accepted sample; mode_q <= mode.
//  - PASS:   cct_output <= cct_input.
//  - ACC:    acc_n = (restart ? 0 : acc) + cct_input, mod 2^WIDTH;
//            carry-out sets ovf; acc <= acc_n; cct_output <= acc_n.
//  - MAX:    acc_n = restart ? cct_input : max(acc, cct_input), unsigned;
//            acc <= acc_n; cct_output <= acc_n.
//  - WINDOW: cct_output <= win_sum_n (see below); acc untouched.
//  - Window history runs on every accepted sample in every mode:
//    hist[0] <= cct_input, hist[i] <= hist[i-1];
//    win_sum_n = win_sum + cct_input - hist[DEPTH-1], mod 2^WIDTH.
//    win_sum tracks the true sum mod 2^WIDTH of the last DEPTH samples;
//    empty slots count as 0.
//    ovf set in WINDOW mode only, when the true (WIDTH+clog2(DEPTH))-bit
//    window sum exceeds 2^WIDTH-1.
//  - Fill state machine: EMPTY (fill=0) -> FILLING (0<fill<DEPTH) -> FULL.
//    fill increments per accepted sample and saturates at DEPTH.
//    window_full=1 only in FULL, registered, same cycle as out_valid of
//    the DEPTH-th sample.
//  - flush=1 on an edge: same state as reset, including mode_q=PASS. An
//    in_valid asserted on that edge is discarded (flush wins). out_valid=0
//    next cycle.
//  - mode changes without in_valid have no effect until the next
//    accepted sample.
//  - All arithmetic is unsigned. There is no backpressure: a sample may
//    be accepted every cycle.
// TESTING (WIDTH=8, DEPTH=4)
//  1 Reset: clear_n low mid-stream -> all outputs 0 immediately, async.
//    Release, idle 3 cycles -> outputs stay 0.
//  2 PASS: 0xAA valid 1 cycle -> next cycle cct_output=0xAA, out_valid=1.
//    Following cycle: out_valid=0, output holds 0xAA.
//  3 ACC: 0xF0, 0x20 back-to-back -> outputs 0xF0, 0x10; ovf=1 from the
//    2nd result on, stays 1 until flush.
//  4 MAX after ACC: 0x30, 0x80, 0x10 -> 0x30 (restart), 0x80, 0x80.
//  5 WINDOW from reset: 1,2,3,4,5 -> 1,3,6,10,14. window_full rises with
//    the 10 result. 0xFF x4 -> ovf=1.
//  6 flush+in_valid=0x55 same edge -> out_valid=0, outputs 0, fill=0.
//    Next ACC sample 0x07 -> 0x07.

Source files
------------

// File: rtl/student_circuit_multimode.sv
// -----------------------------------------------------------------------------
// student_circuit_multimode
//
// Streams WIDTH-bit unsigned samples and produces one registered result per
// accepted sample (latency 1) in one of four modes:
//   0 PASS   - result is the sample itself
//   1 ACC    - running sum mod 2^WIDTH, restarts from 0 on a mode change
//   2 MAX    - running unsigned maximum, restarts from the sample on a mode change
//   3 WINDOW - sum mod 2^WIDTH of the last DEPTH samples (empty slots are 0)
// The window history advances on every accepted sample whatever the mode, so
// switching into WINDOW immediately reports the sum of the recent samples.
//
// Ports
//   clk          rising-edge clock
//   clear_n      asynchronous active-low reset
//   flush        synchronous clear of all state (wins over in_valid)
//   in_valid     cct_input/mode are accepted on this edge when 1
//   mode         operating mode, sampled with in_valid
//   cct_input    unsigned sample
//   cct_output   registered result, holds between samples
//   out_valid    1-cycle pulse: cct_output updated this cycle
//   ovf          sticky overflow of the ACC or WINDOW sum
//   window_full  DEPTH samples accepted since reset/flush
//
// Handshake: there is no backpressure. A sample is accepted on every rising
// edge where in_valid=1 and flush=0; out_valid pulses for exactly one cycle
// after each accepted sample and is 0 otherwise.
// -----------------------------------------------------------------------------
module student_circuit_multimode #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] cct_input,
  output logic [WIDTH-1:0] cct_output,
  output logic             out_valid,
  output logic             ovf,
  output logic             window_full
);

  // The true window sum of DEPTH samples fits in WIDTH+clog2(DEPTH) bits, so
  // the sum is kept at that width; its low WIDTH bits are the reported sum and
  // any upper bit set means the window has overflowed.
  localparam int SW = WIDTH + $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_ACC    = 2'd1;
  localparam logic [1:0] MODE_MAX    = 2'd2;
  localparam logic [1:0] MODE_WINDOW = 2'd3;

  typedef enum logic [1:0] {
    FILL_EMPTY   = 2'd0,
    FILL_FILLING = 2'd1,
    FILL_FULL    = 2'd2
  } fill_state_e;

  // State registers
  logic [1:0]       mode_q,        mode_d;
  logic [WIDTH-1:0] acc_q,         acc_d;
  logic [SW-1:0]    win_sum_q,     win_sum_d;
  logic [WIDTH-1:0] hist_q [DEPTH];
  logic [WIDTH-1:0] hist_d [DEPTH];
  logic [FW-1:0]    fill_q,        fill_d;
  fill_state_e      fill_state_q,  fill_state_d;
  logic [WIDTH-1:0] cct_output_q,  cct_output_d;
  logic             out_valid_q,   out_valid_d;
  logic             ovf_q,         ovf_d;
  logic             window_full_q, window_full_d;

  // Datapath intermediates
  logic             restart;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH-1:0] max_val;
  logic [SW-1:0]    win_sum_n;
  logic             win_ovf;

  always_comb begin
    restart   = (mode != mode_q);
    acc_base  = restart ? '0 : acc_q;
    acc_sum   = {1'b0, acc_base} + {1'b0, cct_input};
    max_val   = (restart || (cct_input > acc_q)) ? cct_input : acc_q;
    // Oldest sample drops out as the new one enters; never goes negative
    // because win_sum_q always includes hist_q[DEPTH-1].
    win_sum_n = win_sum_q + SW'(cct_input) - SW'(hist_q[DEPTH-1]);
    win_ovf   = |win_sum_n[SW-1:WIDTH];
  end

  always_comb begin
    mode_d        = mode_q;
    acc_d         = acc_q;
    win_sum_d     = win_sum_q;
    hist_d        = hist_q;
    fill_d        = fill_q;
    fill_state_d  = fill_state_q;
    cct_output_d  = cct_output_q;
    out_valid_d   = 1'b0;
    ovf_d         = ovf_q;

    if (flush) begin
      // Same state as reset; a sample offered on this edge is discarded.
      mode_d        = MODE_PASS;
      acc_d         = '0;
      win_sum_d     = '0;
      for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
      fill_d        = '0;
      fill_state_d  = FILL_EMPTY;
      cct_output_d  = '0;
      ovf_d         = 1'b0;
    end else if (in_valid) begin
      mode_d      = mode;
      out_valid_d = 1'b1;

      // Window history shifts in every mode.
      hist_d[0] = cct_input;
      for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
      win_sum_d = win_sum_n;

      case (mode)
        MODE_ACC: begin
          acc_d        = acc_sum[WIDTH-1:0];
          cct_output_d = acc_sum[WIDTH-1:0];
          if (acc_sum[WIDTH]) ovf_d = 1'b1;
        end
        MODE_MAX: begin
          acc_d        = max_val;
          cct_output_d = max_val;
        end
        MODE_WINDOW: begin
          cct_output_d = win_sum_n[WIDTH-1:0];
          if (win_ovf) ovf_d = 1'b1;
        end
        default: begin
          cct_output_d = cct_input;
        end
      endcase

      // Fill counter saturates at DEPTH; the FSM mirrors its coarse position.
      if (fill_q != FW'(DEPTH)) fill_d = fill_q + FW'(1);
      case (fill_state_q)
        FILL_EMPTY:   fill_state_d = FILL_FILLING;
        FILL_FILLING: fill_state_d = (fill_q == FW'(DEPTH - 1)) ? FILL_FULL : FILL_FILLING;
        FILL_FULL:    fill_state_d = FILL_FULL;
        default:      fill_state_d = FILL_EMPTY;
      endcase
    end

    // Registered from the next state so it rises together with out_valid of
    // the DEPTH-th sample.
    window_full_d = (fill_state_d == FILL_FULL);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      mode_q        <= MODE_PASS;
      acc_q         <= '0;
      win_sum_q     <= '0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      fill_q        <= '0;
      fill_state_q  <= FILL_EMPTY;
      cct_output_q  <= '0;
      out_valid_q   <= 1'b0;
      ovf_q         <= 1'b0;
      window_full_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      acc_q         <= acc_d;
      win_sum_q     <= win_sum_d;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= hist_d[i];
      fill_q        <= fill_d;
      fill_state_q  <= fill_state_d;
      cct_output_q  <= cct_output_d;
      out_valid_q   <= out_valid_d;
      ovf_q         <= ovf_d;
      window_full_q <= window_full_d;
    end
  end

  assign cct_output  = cct_output_q;
  assign out_valid   = out_valid_q;
  assign ovf         = ovf_q;
  assign window_full = window_full_q;

endmodule

// File: tb/tb_student_circuit_multimode.sv
// -----------------------------------------------------------------------------
// Testbench for student_circuit_multimode (WIDTH=8, DEPTH=4).
// Driver tasks issue samples on the falling edge and push the reference
// model's expected {window_full, ovf, cct_output} into exp_q; a separate
// monitor pops and compares on every falling edge where out_valid=1.
// -----------------------------------------------------------------------------
module tb_student_circuit_multimode;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int unsigned MAXV = (1 << WIDTH) - 1;

  localparam logic [1:0] M_PASS = 2'd0;
  localparam logic [1:0] M_ACC  = 2'd1;
  localparam logic [1:0] M_MAX  = 2'd2;
  localparam logic [1:0] M_WIN  = 2'd3;

  logic             clk;
  logic             clear_n;
  logic             flush;
  logic             in_valid;
  logic [1:0]       mode;
  logic [WIDTH-1:0] cct_input;
  logic [WIDTH-1:0] cct_output;
  logic             out_valid;
  logic             ovf;
  logic             window_full;

  int total = 0;
  int bad   = 0;

  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] mon_exp;

  student_circuit_multimode #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .mode        (mode),
    .cct_input   (cct_input),
    .cct_output  (cct_output),
    .out_valid   (out_valid),
    .ovf         (ovf),
    .window_full (window_full)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test done earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int unsigned m_win[$];   // most recent sample at the front
  int unsigned m_acc;
  logic [1:0]  m_mode;
  logic        m_ovf;
  int          m_fill;

  function automatic void model_reset();
    m_win.delete();
    m_acc  = 0;
    m_mode = M_PASS;
    m_ovf  = 1'b0;
    m_fill = 0;
  endfunction

  function automatic void model_step(input logic [1:0] md, input int unsigned x);
    logic        restart;
    int unsigned sum;
    int unsigned a;
    int unsigned res;
    restart = (md != m_mode);
    m_mode  = md;
    m_win.push_front(x);
    if (m_win.size() > DEPTH) void'(m_win.pop_back());
    sum = 0;
    foreach (m_win[i]) sum += m_win[i];
    res = 0;
    case (md)
      M_PASS: res = x;
      M_ACC: begin
        a = (restart ? 0 : m_acc) + x;
        if (a > MAXV) m_ovf = 1'b1;
        m_acc = a % (MAXV + 1);
        res   = m_acc;
      end
      M_MAX: begin
        if (restart || x > m_acc) m_acc = x;
        res = m_acc;
      end
      default: begin
        res = sum % (MAXV + 1);
        if (sum > MAXV) m_ovf = 1'b1;
      end
    endcase
    if (m_fill < DEPTH) m_fill++;
    exp_q.push_back({(m_fill == DEPTH), m_ovf, WIDTH'(res)});
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every result the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (clear_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got out_valid=1 cct_output=0x%0h, expected no result (t=%0t)",
                 cct_output, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result{wfull,ovf,out}", 32'({window_full, ovf, cct_output}), 32'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [1:0] md, input logic [WIDTH-1:0] d,
                       input logic fl);
    @(negedge clk);
    in_valid  = v;
    mode      = md;
    cct_input = d;
    flush     = fl;
    if (fl) model_reset();
    else if (v) model_step(md, d);
  endtask

  task automatic send(input logic [1:0] md, input logic [WIDTH-1:0] d);
    drive(1'b1, md, d, 1'b0);
  endtask

  // Idle cycle, then check that nothing new is presented and outputs hold.
  task automatic hold_check(input string name, input logic [WIDTH-1:0] o,
                            input logic ov, input logic wf);
    drive(1'b0, mode, WIDTH'($urandom), 1'b0);
    check({name, ".out_valid"},   32'(out_valid),   32'(0));
    check({name, ".cct_output"},  32'(cct_output),  32'(o));
    check({name, ".ovf"},         32'(ovf),         32'(ov));
    check({name, ".window_full"}, 32'(window_full), 32'(wf));
  endtask

  task automatic check_zero_now(input string name);
    check({name, ".cct_output"},  32'(cct_output),  32'(0));
    check({name, ".out_valid"},   32'(out_valid),   32'(0));
    check({name, ".ovf"},         32'(ovf),         32'(0));
    check({name, ".window_full"}, 32'(window_full), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [1:0]       cur_mode;
  logic [WIDTH-1:0] rnd_d;
  logic             rnd_v;
  int               rnd_r;

  initial begin
    clear_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    mode      = M_PASS;
    cct_input = '0;
    model_reset();

    // 1: reset state, then idle after release
    #12;
    check_zero_now("reset");
    @(negedge clk);
    clear_n = 1'b1;
    for (int i = 0; i < 3; i++) hold_check("idle_after_reset", 8'h00, 1'b0, 1'b0);

    // 2: PASS
    send(M_PASS, 8'hAA);
    drive(1'b0, M_PASS, 8'h00, 1'b0);
    hold_check("pass_hold", 8'hAA, 1'b0, 1'b0);

    // 3: ACC with carry
    send(M_ACC, 8'hF0);
    send(M_ACC, 8'h20);
    drive(1'b0, M_ACC, 8'h00, 1'b0);
    hold_check("acc_hold", 8'h10, 1'b1, 1'b0);

    // 4: MAX after ACC (restart), mode change without in_valid ignored
    drive(1'b0, M_WIN, 8'h99, 1'b0);
    send(M_MAX, 8'h30);
    send(M_MAX, 8'h80);
    send(M_MAX, 8'h10);
    drive(1'b0, M_MAX, 8'h00, 1'b0);
    hold_check("max_hold", 8'h80, 1'b1, 1'b1);

    // 5: WINDOW from cleared state, then window overflow
    drive(1'b0, M_PASS, 8'h00, 1'b1);
    hold_check("flush_clear", 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) send(M_WIN, WIDTH'(i));
    drive(1'b0, M_WIN, 8'h00, 1'b0);
    hold_check("win_hold", 8'h0E, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(M_WIN, 8'hFF);
    drive(1'b0, M_WIN, 8'h00, 1'b0);
    hold_check("win_ovf_hold", 8'hFC, 1'b1, 1'b1);

    // 6: flush wins over in_valid
    drive(1'b1, M_ACC, 8'h55, 1'b1);
    hold_check("flush_with_valid", 8'h00, 1'b0, 1'b0);
    send(M_ACC, 8'h07);
    drive(1'b0, M_ACC, 8'h00, 1'b0);
    hold_check("acc_after_flush", 8'h07, 1'b0, 1'b0);

    // Randomized stream with occasional flushes
    cur_mode = M_ACC;
    for (int i = 0; i < 500; i++) begin
      rnd_r = int'($urandom_range(0, 49));
      if ($urandom_range(0, 3) == 0) cur_mode = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       rnd_d = '0;
        1:       rnd_d = '1;
        default: rnd_d = WIDTH'($urandom);
      endcase
      rnd_v = ($urandom_range(0, 3) != 0);
      drive(rnd_v, cur_mode, rnd_d, rnd_r == 0);
    end
    drive(1'b0, cur_mode, 8'h00, 1'b0);
    drive(1'b0, cur_mode, 8'h00, 1'b0);
    check("drain_after_random", 32'(exp_q.size()), 32'(0));

    // Asynchronous reset while a result is being presented
    send(M_ACC, 8'hC4);
    send(M_ACC, 8'h44);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    clear_n = 1'b0;
    #1;
    check_zero_now("async_reset");
    exp_q.delete();
    model_reset();
    @(negedge clk);
    clear_n = 1'b1;
    for (int i = 0; i < 3; i++) hold_check("idle_after_async_reset", 8'h00, 1'b0, 1'b0);
    send(M_MAX, 8'h21);
    drive(1'b0, M_MAX, 8'h00, 1'b0);
    drive(1'b0, M_MAX, 8'h00, 1'b0);
    check("final_drain", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
